// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request, hazard-check and register-file write bundle
//
// Purpose: groups every non-clock signal of the write-back controller.
// Ports (slave = controller view):
//   alu_valid/alu_addr/alu_data -> alu_ready   ALU write-back handshake
//   mem_valid/mem_addr/mem_data -> mem_ready   load write-back handshake
//   issue_valid/issue_addr                     destination of an issuing instruction
//   chk_addr_a/chk_addr_b -> hazard_a/hazard_b read-after-write hazard lookup
//   rf_write/rf_wr_addr/rf_wr_data             register file write port
//   idle                                       nothing pending and no write in flight
`timescale 1ns/1ps
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] chk_addr_a;
  logic [ADDR_W-1:0] chk_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              idle;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr, chk_addr_a, chk_addr_b,
    output alu_ready, mem_ready, hazard_a, hazard_b,
    output rf_write, rf_wr_addr, rf_wr_data, idle
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr, chk_addr_a, chk_addr_b,
    input  alu_ready, mem_ready, hazard_a, hazard_b,
    input  rf_write, rf_wr_addr, rf_wr_data, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with pending-write scoreboard
//
// Purpose: shares the register file's single write port between the ALU and
// the load unit and tracks which registers still have a write outstanding.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      regfile_wb_arbiter_if.slave (requests, hazard checks, RF write port)
`timescale 1ns/1ps
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } last_t;

  last_t             last;
  logic [NREG-1:0]   pending;
  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_wr_addr_q;
  logic [DATA_W-1:0] rf_wr_data_q;

  logic              grant_alu;
  logic              grant_mem;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  // A lone requester always wins; on a conflict the loser of the previous
  // grant goes first, which gives strict alternation under continuous load.
  always_comb begin
    grant_alu = bus.alu_valid & (~bus.mem_valid | (last == LAST_MEM));
    grant_mem = bus.mem_valid & (~bus.alu_valid | (last == LAST_ALU));
  end

  // The write in flight retires its register at the edge that commits it;
  // a new issue to that register in the same cycle must survive the clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid) set_mask[bus.issue_addr] = 1'b1;
    if (rf_write_q)      clr_mask[rf_wr_addr_q]   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last         <= LAST_MEM;
      pending      <= '0;
      rf_write_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (grant_alu) begin
        last         <= LAST_ALU;
        rf_write_q   <= 1'b1;
        rf_wr_addr_q <= bus.alu_addr;
        rf_wr_data_q <= bus.alu_data;
      end else if (grant_mem) begin
        last         <= LAST_MEM;
        rf_write_q   <= 1'b1;
        rf_wr_addr_q <= bus.mem_addr;
        rf_wr_data_q <= bus.mem_data;
      end else begin
        rf_write_q   <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = grant_alu;
  assign bus.mem_ready  = grant_mem;
  // No bypass: the hazard covers the cycle in which the write is still on the port.
  assign bus.hazard_a   = pending[bus.chk_addr_a];
  assign bus.hazard_b   = pending[bus.chk_addr_b];
  assign bus.rf_write   = rf_write_q;
  assign bus.rf_wr_addr = rf_wr_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.idle       = ~(|pending) & ~rf_write_q;
endmodule
